// File: rtl/lcd_show_win.sv
// lcd_show_win: draws a PIC_W x PIC_H 1-bpp bitmap at a run-time (x,y) origin.
// It first sends the CASET/RASET/RAMWR window setup. It then expands each
// bitmap bit to the fg or bg RGB565 colour and sends it as two {DC,byte} words.
// Every word is handed to lcd_write with an en_write/wr_done handshake.
module lcd_show_win #(
    parameter int PIC_W   = 240,
    parameter int PIC_H   = 240,
    parameter int ADDR_W  = 9,
    parameter int LCD_W   = 240,
    parameter int LCD_H   = 320,
    parameter int ROM_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [8:0]        start_x,
    input  logic [8:0]        start_y,
    input  logic [15:0]       fg_color,
    input  logic [15:0]       bg_color,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIC_W-1:0]  rom_q,
    output logic [8:0]        show_pic_data,
    output logic              en_write_show_pic,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = (PIC_W > 1) ? $clog2(PIC_W) : 1;
    localparam int RW = (PIC_H > 1) ? $clog2(PIC_H) : 1;
    localparam int LW = 2;  // ROM_LAT is limited to 0..3

    typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT, FETCH, DONE} state_t;
    state_t state, state_nxt;

    logic [8:0]       x_l, y_l;
    logic [15:0]      fg_l, bg_l;
    logic             pix;       // 0: window setup words, 1: pixel words
    logic [3:0]       widx;      // setup word index 0..10
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             lo_sel;    // 0: colour high byte, 1: low byte
    logic [LW-1:0]    lat;
    logic [PIC_W-1:0] row_buf;

    logic [15:0]   xs, xe, ys, ye, color;
    logic [CW-1:0] pix_idx;
    logic [8:0]    word;
    logic          oob, word_last, col_last, row_last, lat_hit;

    // The window must fit on the panel. The compare is 10 bits wide, so x+W cannot wrap.
    assign oob = ((10'(x_l) + 10'(PIC_W)) > 10'(LCD_W)) ||
                 ((10'(y_l) + 10'(PIC_H)) > 10'(LCD_H));

    assign xs = 16'(x_l);
    assign ys = 16'(y_l);
    assign xe = 16'(x_l) + 16'(PIC_W - 1);
    assign ye = 16'(y_l) + 16'(PIC_H - 1);

    assign word_last = (widx == 4'd10);
    assign col_last  = (col == CW'(PIC_W - 1));
    assign row_last  = (row == RW'(PIC_H - 1));
    assign lat_hit   = (lat == LW'(ROM_LAT));

    // The MSB of the ROM row is the leftmost pixel.
    assign pix_idx  = CW'(PIC_W - 1) - col;
    assign color    = row_buf[pix_idx] ? fg_l : bg_l;
    assign rom_addr = ADDR_W'(row);

    // Word for the current slot. It stays stable from SEND through WAIT.
    always_comb begin
        word = 9'h02C;
        if (pix) begin
            word = lo_sel ? {1'b1, color[7:0]} : {1'b1, color[15:8]};
        end else begin
            case (widx)
                4'd0:    word = 9'h02A;
                4'd1:    word = {1'b1, xs[15:8]};
                4'd2:    word = {1'b1, xs[7:0]};
                4'd3:    word = {1'b1, xe[15:8]};
                4'd4:    word = {1'b1, xe[7:0]};
                4'd5:    word = 9'h02B;
                4'd6:    word = {1'b1, ys[15:8]};
                4'd7:    word = {1'b1, ys[7:0]};
                4'd8:    word = {1'b1, ye[15:8]};
                4'd9:    word = {1'b1, ye[7:0]};
                default: word = 9'h02C;
            endcase
        end
    end

    // State register. A reset drops any transfer in progress immediately.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt         = state;
        en_write_show_pic = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        err               = 1'b0;
        show_pic_data     = 9'h000;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: begin
                err       = oob;
                state_nxt = oob ? IDLE : SEND;
            end
            SEND: begin
                en_write_show_pic = 1'b1;
                busy              = 1'b1;
                show_pic_data     = word;
                state_nxt         = WAIT;
            end
            WAIT: begin
                busy          = 1'b1;
                show_pic_data = word;
                if (wr_done) begin
                    if (!pix)          state_nxt = word_last ? FETCH : SEND;
                    else if (!lo_sel)  state_nxt = SEND;
                    else if (!col_last) state_nxt = SEND;
                    else               state_nxt = row_last ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (lat_hit) state_nxt = SEND;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, step the word/column/row counters and load the ROM row.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x_l     <= '0;
            y_l     <= '0;
            fg_l    <= '0;
            bg_l    <= '0;
            pix     <= 1'b0;
            widx    <= '0;
            col     <= '0;
            row     <= '0;
            lo_sel  <= 1'b0;
            lat     <= '0;
            row_buf <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x_l    <= start_x;
                    y_l    <= start_y;
                    fg_l   <= fg_color;
                    bg_l   <= bg_color;
                    pix    <= 1'b0;
                    widx   <= '0;
                    col    <= '0;
                    row    <= '0;
                    lo_sel <= 1'b0;
                    lat    <= '0;
                end
                WAIT: if (wr_done) begin
                    if (!pix) begin
                        if (word_last) begin
                            pix <= 1'b1;
                            lat <= '0;
                        end else begin
                            widx <= widx + 4'd1;
                        end
                    end else if (!lo_sel) begin
                        lo_sel <= 1'b1;
                    end else begin
                        lo_sel <= 1'b0;
                        if (!col_last) begin
                            col <= col + CW'(1);
                        end else begin
                            col <= '0;
                            lat <= '0;
                            if (!row_last) row <= row + RW'(1);
                        end
                    end
                end
                FETCH: begin
                    if (lat_hit) begin
                        row_buf <= rom_q;
                        lat     <= '0;
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_show_win.sv
// tb_lcd_show_win: four DUTs (ROM_LAT 0..3), each with its own delayed ROM and wr_done
// responder, all driven by the same directed start sequence.
module tb_lcd_show_win;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, inj;
    logic [8:0]  sx, sy;
    logic [15:0] fg, bg;

    logic [3:0][8:0] addr_w, dat_w;
    logic [3:0]      en_w, busy_w, done_w, err_w;

    logic [8:0] wlog [4][256];
    logic [8:0] alog [4][256];
    int n [4];
    int dc [4];
    int ec [4];

    int n_chk = 0;
    int n_pass = 0;
    int b [4];
    int dc0, nd, nb, eb, k;

    logic [8:0] SET_A [11] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10D,
                               9'h02B, 9'h100, 9'h114, 9'h100, 9'h115, 9'h02C};
    logic [8:0] SET_C [11] = '{9'h02A, 9'h100, 9'h1EC, 9'h100, 9'h1EF,
                               9'h02B, 9'h101, 9'h13E, 9'h101, 9'h13F, 9'h02C};
    logic [8:0] PIX [16]   = '{9'h1F8, 9'h100, 9'h100, 9'h11F, 9'h100, 9'h11F, 9'h1F8, 9'h100,
                               9'h100, 9'h11F, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h100, 9'h11F};

    function automatic logic [3:0] rom_rd(input logic [8:0] a);
        case (a)
            9'd0:    return 4'b1001;
            9'd1:    return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lat
        logic [8:0] a1, a2, a3;
        logic [3:0] rq;
        logic       wr;
        int         cnt;

        // ROM whose output trails rom_addr by g cycles; wr_done 3 cycles after each strobe.
        always @(posedge clk) begin
            a1 <= addr_w[g];
            a2 <= a1;
            a3 <= a2;
            if (rst)            cnt <= 0;
            else if (en_w[g])   cnt <= 3;
            else if (cnt != 0)  cnt <= cnt - 1;
        end
        assign rq = rom_rd(g == 0 ? addr_w[g] : g == 1 ? a1 : g == 2 ? a2 : a3);
        assign wr = (cnt == 1) | inj;

        lcd_show_win #(.PIC_W(4), .PIC_H(2), .ADDR_W(9), .LCD_W(240), .LCD_H(320),
                       .ROM_LAT(g)) u_dut (
            .sys_clk(clk), .sys_rst(rst), .start(start), .start_x(sx), .start_y(sy),
            .fg_color(fg), .bg_color(bg), .wr_done(wr), .rom_addr(addr_w[g]), .rom_q(rq),
            .show_pic_data(dat_w[g]), .en_write_show_pic(en_w[g]), .busy(busy_w[g]),
            .done(done_w[g]), .err(err_w[g]));
    end

    // Log every strobed word with its rom_addr, and count done/err pulses.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (en_w[i]) begin
                if (n[i] < 256) begin
                    wlog[i][n[i]] <= dat_w[i];
                    alog[i][n[i]] <= addr_w[i];
                end
                n[i] <= n[i] + 1;
            end
            if (done_w[i]) dc[i] <= dc[i] + 1;
            if (err_w[i])  ec[i] <= ec[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic kick(input logic [8:0] x, input logic [8:0] y);
        @(negedge clk);
        sx = x; sy = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_n(input int target, input int budget);
        int c = 0;
        while (n[1] < target && c < budget) begin @(negedge clk); c++; end
        if (n[1] < target) chk("wait_strobes", n[1], target);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (dc[1] < target && c < budget) begin @(negedge clk); c++; end
        if (dc[1] < target) chk("wait_done", dc[1], target);
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) b[i] = n[i];
        dc0 = dc[1];
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inj = 1'b0;
        sx = '0; sy = '0; fg = 16'hF800; bg = 16'h001F;
        repeat (3) @(negedge clk);
        chk("rst_en", en_w, 0);
        chk("rst_busy", busy_w, 0);
        chk("rst_done", done_w, 0);
        chk("rst_err", err_w, 0);
        chk("rst_addr", addr_w[1], 0);
        chk("rst_data", dat_w[1], 0);
        rst = 1'b0;

        // spurious wr_done while idle
        @(negedge clk); inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_wr_busy", busy_w[1], 0);
        chk("idle_wr_strobes", n[1], 0);

        // draw at (10,20), spurious wr_done in a setup SEND, ignored mid-draw start
        snap();
        kick(9'd10, 9'd20);
        k = 0;
        while (!(en_w[1] && n[1] == b[1] + 2) && k < 100) begin @(negedge clk); k++; end
        chk("a_inj_at_send", en_w[1], 1);
        inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        wait_n(b[1] + 15, 300);
        kick(9'd100, 9'd20);
        wait_done(dc0 + 1, 600);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_count%0d", i), n[i] - b[i], 27);
            for (int j = 0; j < 16; j++)
                chk($sformatf("a_pix%0d_%0d", i, j), wlog[i][b[i] + 11 + j], PIX[j]);
            chk($sformatf("a_addr0_%0d", i), alog[i][b[i] + 11], 0);
            chk($sformatf("a_addr1_%0d", i), alog[i][b[i] + 26], 1);
        end
        for (int j = 0; j < 11; j++)
            chk($sformatf("a_setup%0d", j), wlog[1][b[1] + j], SET_A[j]);
        chk("a_done_once", dc[1] - dc0, 1);
        chk("a_busy_low", busy_w[1], 0);
        chk("a_no_err", ec[1], 0);

        // (237,0) is out of bounds
        nb = n[1]; eb = ec[1];
        kick(9'd237, 9'd0);
        chk("b_err", err_w[1], 1);
        chk("b_busy", busy_w[1], 0);
        @(negedge clk);
        chk("b_err_1cyc", err_w[1], 0);
        chk("b_busy_after", busy_w[1], 0);
        repeat (5) @(negedge clk);
        chk("b_no_strobe", n[1], nb);
        chk("b_err_cnt", ec[1], eb + 1);

        // (236,318) just fits
        snap();
        kick(9'd236, 9'd318);
        wait_done(dc0 + 1, 600);
        repeat (20) @(negedge clk);
        chk("c_count", n[1] - b[1], 27);
        for (int j = 0; j < 11; j++)
            chk($sformatf("c_setup%0d", j), wlog[1][b[1] + j], SET_C[j]);
        for (int j = 0; j < 16; j++)
            chk($sformatf("c_pix%0d", j), wlog[1][b[1] + 11 + j], PIX[j]);

        // reset during the 5th pixel WAIT, then restart
        snap();
        kick(9'd10, 9'd20);
        wait_n(b[1] + 16, 300);
        rst = 1'b1;
        @(negedge clk);
        chk("d_en", en_w[1], 0);
        chk("d_busy", busy_w[1], 0);
        chk("d_done", done_w[1], 0);
        rst = 1'b0;
        nd = n[1];
        repeat (10) @(negedge clk);
        chk("d_no_done", dc[1], dc0);
        chk("d_no_strobe", n[1], nd);
        snap();
        kick(9'd10, 9'd20);
        wait_n(b[1] + 1, 50);
        chk("d_restart", wlog[1][b[1]], 9'h02A);
        wait_done(dc0 + 1, 600);
        repeat (5) @(negedge clk);
        chk("d_count", n[1] - b[1], 27);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
